fifo_rd_ctrl: RTL

- Read-side controller of the asynchronous FIFO; the counterpart of the write port on the dual-port memory.
- Lives entirely in the read clock domain.
- Synchronises the Gray-coded write pointer, keeps the binary/Gray read pointer and the empty flag, and drives the memory's asynchronous read address.
- Presents popped words through a registered valid/ready output stage, and returns its Gray read pointer to the write domain for full detection.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/fifo_rd_ctrl.sv | 75 +++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for both sides of the asynchronous FIFO: pointer code conversions
// and default geometry.
package fifo_pkg;

    localparam int default_addr_size  = 4;
    localparam int default_word_width = 8;

    // Conversions work on a 32-bit container; callers zero-extend and slice.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into the local clock domain.
module sync_2ff #(
    parameter int width = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic [width-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO: synchronised write pointer, read
// pointer, empty flag, level estimate and a registered valid/ready output stage.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int addr_size  = default_addr_size,
    parameter int word_width = default_word_width
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [addr_size:0]    wptr_gray,
    input  logic [word_width-1:0] data_r,
    output logic [addr_size-1:0]  addr_r,
    output logic [addr_size:0]    rptr_gray,
    output logic                  empty,
    output logic                  out_valid,
    output logic [word_width-1:0] out_data,
    input  logic                  out_ready,
    output logic [addr_size:0]    rd_level
);

    localparam int pw = addr_size + 1;

    logic [pw-1:0] wq2;
    logic [pw-1:0] rbin;
    logic [pw-1:0] rbin_next;
    logic [pw-1:0] rgray_next;
    logic [pw-1:0] level_next;
    logic [31:0]   gray_wide;
    logic [31:0]   wbin_wide;
    logic          pop;
    logic          unused_high_bits;

    sync_2ff #(.width(pw)) u_wptr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (wptr_gray),
        .q     (wq2)
    );

    // Refill the output register whenever it is free or being drained this cycle.
    assign pop        = !empty && (!out_valid || out_ready);
    assign rbin_next  = rbin + {{(pw-1){1'b0}}, pop};
    assign gray_wide  = bin2gray({{(32-pw){1'b0}}, rbin_next});
    assign rgray_next = gray_wide[pw-1:0];
    assign wbin_wide  = gray2bin({{(32-pw){1'b0}}, wq2});
    assign level_next = wbin_wide[pw-1:0] - rbin_next;
    assign addr_r     = rbin[addr_size-1:0];

    assign unused_high_bits = &{1'b0, gray_wide[31:pw], wbin_wide[31:pw]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbin      <= '0;
            rptr_gray <= '0;
            empty     <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            rd_level  <= '0;
        end else begin
            rbin      <= rbin_next;
            rptr_gray <= rgray_next;
            // Compare against the post-pop pointer so the last pop raises empty at once.
            empty     <= (rgray_next == wq2);
            rd_level  <= level_next;
            if (pop) begin
                out_data  <= data_r;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
